arb_req_ctrl: RTL and testbench

Request-side controller for the 4-way round-robin arbiter. It queues job requests from four masters and drives the arbiter's `req` vector. It consumes the returned one-hot `grant` as per-cycle transfer beats, signals job completion, and polices the grant stream for protocol violations. It sits between the master agents and the arbiter, as the requester end of the req/grant interface.

---
 rtl/arb_req_ctrl_if.sv | 39 +++
 rtl/arb_req_ctrl.sv | 90 +++++++++
 tb/tb_arb_req_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_req_ctrl_if.sv
// Requester-side bundle between master agents, arb_req_ctrl and the round-robin arbiter.
// The master modport is the controller; slave is the agent/arbiter environment.
interface arb_req_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] push;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] beat;
    logic [N-1:0] done;
    logic [N-1:0] full;
    logic [N-1:0] overflow;
    logic         proto_err;
    logic         clr_err;

    modport master (
        input  push,
        input  grant,
        input  clr_err,
        output req,
        output beat,
        output done,
        output full,
        output overflow,
        output proto_err
    );

    modport slave (
        output push,
        output grant,
        output clr_err,
        input  req,
        input  beat,
        input  done,
        input  full,
        input  overflow,
        input  proto_err
    );
endinterface

// File: rtl/arb_req_ctrl.sv
// Request-side controller for the N-way round-robin arbiter: queues jobs per channel,
// turns grants into beats, pulses done on job completion and polices the grant stream.
//
// Per-channel state is implied by the pending count rather than a state register:
//   state       | meaning
//   IDLE        | pend == 0, req low
//   REQ/ACTIVE  | pend != 0, req high, left counts beats still owed by the head job
module arb_req_ctrl #(
    parameter int N         = 4,
    parameter int DEPTH     = 7,
    parameter int BURST_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    arb_req_ctrl_if.master bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [LW-1:0] BURST_P = LW'(BURST_LEN);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    logic [N-1:0][PW-1:0] pend_q, pend_d;
    logic [N-1:0][LW-1:0] left_q, left_d;
    logic [N-1:0]         req_q, req_d;
    logic [N-1:0]         done_q, full_q, full_d;
    logic [N-1:0]         ovf_q, ovf_d;
    logic                 perr_q, perr_d;

    logic [N-1:0]         vbeat, cmpl, acc, drop;
    logic                 multi, stray;

    always_comb begin
        vbeat  = bus.grant & req_q;
        multi  = |(bus.grant & (bus.grant - N'(1)));
        stray  = |(bus.grant & ~req_q);
        cmpl   = '0;
        acc    = '0;
        drop   = '0;
        pend_d = pend_q;
        left_d = left_q;
        req_d  = '0;
        full_d = '0;
        for (int i = 0; i < N; i++) begin
            cmpl[i] = vbeat[i] & (left_q[i] == ONE_L);
            // A completing job frees its slot on this same edge, so a push is taken even when full.
            acc[i]  = bus.push[i] & ((pend_q[i] != DEPTH_P) | cmpl[i]);
            drop[i] = bus.push[i] & ~acc[i];
            pend_d[i] = pend_q[i] + PW'(acc[i]) - PW'(cmpl[i]);
            if (cmpl[i]) begin
                left_d[i] = BURST_P;
            end else if (vbeat[i]) begin
                left_d[i] = left_q[i] - ONE_L;
            end
            req_d[i]  = (pend_d[i] != '0);
            full_d[i] = (pend_d[i] == DEPTH_P);
        end
        // New events win over a simultaneous clear.
        ovf_d  = (ovf_q & ~{N{bus.clr_err}}) | drop;
        perr_d = (perr_q & ~bus.clr_err) | multi | stray;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            left_q <= {N{BURST_P}};
            req_q  <= '0;
            done_q <= '0;
            full_q <= '0;
            ovf_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            left_q <= left_d;
            req_q  <= req_d;
            done_q <= cmpl;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            perr_q <= perr_d;
        end
    end

    assign bus.req       = req_q;
    assign bus.beat      = bus.grant & req_q;
    assign bus.done      = done_q;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a job/beat-count model.
module tb_arb_req_ctrl;
    localparam int N         = 4;
    localparam int DEPTH     = 7;
    localparam int BURST_LEN = 2;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    arb_req_ctrl_if #(.N(N)) bus ();

    arb_req_ctrl #(.N(N), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: jobs queued per channel and beats already taken by the head job.
    int       m_jobs  [N];
    int       m_taken [N];
    bit [3:0] m_req, m_full, m_done, m_ovf;
    bit       m_perr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_jobs[i]  = 0;
                m_taken[i] = 0;
            end
            m_done = '0;
            m_ovf  = '0;
            m_perr = 1'b0;
        end else begin
            int  ones;
            bit  illegal;
            ones    = 0;
            illegal = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.grant[i]) begin
                    ones++;
                    if (m_jobs[i] == 0) illegal = 1'b1;
                end
            end
            if (ones > 1) illegal = 1'b1;
            for (int i = 0; i < N; i++) begin
                bit fin;
                bit accept;
                fin = 1'b0;
                if (bus.grant[i] && m_jobs[i] > 0) begin
                    m_taken[i]++;
                    if (m_taken[i] == BURST_LEN) begin
                        fin        = 1'b1;
                        m_taken[i] = 0;
                    end
                end
                accept     = bus.push[i] && (m_jobs[i] < DEPTH || fin);
                m_jobs[i]  = m_jobs[i] + (accept ? 1 : 0) - (fin ? 1 : 0);
                m_done[i]  = fin;
                m_ovf[i]   = (m_ovf[i] && !bus.clr_err) || (bus.push[i] && !accept);
            end
            m_perr = (m_perr && !bus.clr_err) || illegal;
        end
        for (int i = 0; i < N; i++) begin
            m_req[i]  = (m_jobs[i] > 0);
            m_full[i] = (m_jobs[i] == DEPTH);
        end
    end

    always @(negedge clk) begin
        check("req",       32'(bus.req),       32'(m_req));
        check("beat",      32'(bus.beat),      32'(bus.grant & m_req));
        check("done",      32'(bus.done),      32'(m_done));
        check("full",      32'(bus.full),      32'(m_full));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
        check("proto_err", 32'(bus.proto_err), 32'(m_perr));
    end

    task automatic step(input logic [3:0] p, input logic [3:0] g, input logic c);
        bus.push    = p;
        bus.grant   = g;
        bus.clr_err = c;
        @(posedge clk);
        #2;
        bus.push    = '0;
        bus.grant   = '0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int rcnt;
        int dpos [3];
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        bus.push    = '0;
        bus.grant   = '0;
        bus.clr_err = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_req",  32'(bus.req),  32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_flags", 32'({bus.overflow, bus.full, bus.proto_err}), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single job on ch0
        step(4'b0001, 4'b0000, 1'b0);
        check("single_req1", 32'(bus.req), 32'h1);
        bus.grant = 4'b0001;
        #1 check("single_beat1", 32'(bus.beat), 32'h1);
        step(4'b0000, 4'b0001, 1'b0);
        check("single_req2", 32'(bus.req), 32'h1);
        check("single_nodone", 32'(bus.done), 32'h0);
        bus.grant = 4'b0001;
        #1 check("single_beat2", 32'(bus.beat), 32'h1);
        step(4'b0000, 4'b0001, 1'b0);
        check("single_done", 32'(bus.done), 32'h1);
        check("single_idle", 32'(bus.req), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);
        check("single_done_once", 32'(bus.done), 32'h0);

        // back-to-back jobs on ch1
        dcnt = 0;
        rcnt = 0;
        for (int n = 0; n < 10; n++) begin
            step((n < 3) ? 4'b0010 : 4'b0000, m_req & 4'b0010, 1'b0);
            if (bus.req[1]) rcnt++;
            if (bus.done[1]) begin
                if (dcnt < 3) dpos[dcnt] = n;
                dcnt++;
            end
        end
        check("b2b_req_cycles", 32'(rcnt), 32'd6);
        check("b2b_done_count", 32'(dcnt), 32'd3);
        check("b2b_spacing", 32'(dpos[1] - dpos[0]) << 8 | 32'(dpos[2] - dpos[1]), 32'h0202);

        // round-robin sharing
        step(4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(4'b0000, 4'(1 << (k % 4)), 1'b0);
            check("rr_done", 32'(bus.done), (k >= 4) ? (32'h1 << (k - 4)) : 32'h0);
        end
        check("rr_idle", 32'(bus.req), 32'h0);

        // protocol errors
        step(4'b0011, 4'b0000, 1'b0);
        check("perr_req", 32'(bus.req), 32'h3);
        step(4'b0000, 4'b0011, 1'b0);
        check("perr_multi", 32'(bus.proto_err), 32'h1);
        check("perr_multi_nodone", 32'(bus.done), 32'h0);
        step(4'b0000, 4'b0001, 1'b0);
        check("perr_ch0_done", 32'(bus.done), 32'h1);
        step(4'b0000, 4'b0010, 1'b0);
        check("perr_ch1_done", 32'(bus.done), 32'h2);
        step(4'b0000, 4'b0000, 1'b1);
        check("perr_clr", 32'(bus.proto_err), 32'h0);
        step(4'b0000, 4'b0100, 1'b0);
        check("perr_stray", 32'(bus.proto_err), 32'h1);
        check("perr_stray_idle", 32'(bus.req), 32'h0);
        step(4'b0000, 4'b0000, 1'b1);

        // overflow on ch2
        repeat (8) step(4'b0100, 4'b0000, 1'b0);
        check("ovf_full", 32'(bus.full), 32'h4);
        check("ovf_flag", 32'(bus.overflow), 32'h4);
        check("ovf_model_pend", 32'(m_jobs[2]), 32'd7);
        step(4'b0000, 4'b0000, 1'b1);
        check("ovf_clr", 32'(bus.overflow), 32'h0);
        step(4'b0000, 4'b0100, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        check("ovf_push_done", 32'(bus.done), 32'h4);
        check("ovf_still_full", 32'(bus.full), 32'h4);
        check("ovf_not_reset", 32'(bus.overflow), 32'h0);
        repeat (14) step(4'b0000, 4'b0100, 1'b0);
        check("ovf_drained", 32'(bus.req), 32'h0);

        // reset mid-job on ch3
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b1000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        check("mid_pre_perr", 32'(bus.proto_err), 32'h1);
        check("mid_pre_req", 32'(bus.req), 32'h8);
        rst = 1'b1;
        #1;
        check("mid_async_req", 32'(bus.req), 32'h0);
        check("mid_async_flags", 32'({bus.overflow, bus.full, bus.proto_err}), 32'h0);
        check("mid_async_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 4; n++) begin
            step(4'b0000, 4'b0000, 1'b0);
            if (bus.done != 0) dcnt++;
        end
        check("mid_no_done", 32'(dcnt), 32'd0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] p;
            logic [3:0] g;
            int         mode;
            int         pick;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 9);
            g    = '0;
            if (mode <= 6) begin
                if (m_req != 0) begin
                    pick = $urandom_range(0, 3);
                    while (!m_req[pick]) pick = (pick + 1) % 4;
                    g[pick] = 1'b1;
                end
            end else if (mode == 7) begin
                g = 4'($urandom_range(0, 15));
            end else if (mode == 9) begin
                g[$urandom_range(0, 3)] = 1'b1;
            end
            step(p, g, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
